// File: rtl/io_pkg.sv
// io_pkg
// Shared definitions for the memory-mapped parallel I/O bank.
//   - Register offsets inside the 16-address I/O window.
//   - io_reg_e: which register class an offset selects.
//   - decode_ofs(): maps a window offset to its register class.
package io_pkg;

    localparam int         IO_WIN_BITS = 4;       // 16-address window
    localparam logic [3:0] OFS_OUT0    = 4'd0;    // OUT[k]  at OFS_OUT0 + k
    localparam logic [3:0] OFS_IN0     = 4'd8;    // IN[k]   at OFS_IN0 + k
    localparam logic [3:0] OFS_STATUS  = 4'd14;   // change flags, write-1-to-clear
    localparam logic [3:0] OFS_MASK    = 4'd15;   // interrupt enables

    typedef enum logic [2:0] {
        REG_NONE   = 3'd0,
        REG_OUT    = 3'd1,
        REG_IN     = 3'd2,
        REG_STATUS = 3'd3,
        REG_MASK   = 3'd4
    } io_reg_e;

    // Offsets past the last implemented OUT/IN channel fall through to REG_NONE,
    // which reads as zero and ignores writes.
    function automatic io_reg_e decode_ofs(input logic [3:0] ofs,
                                           input int         n_out,
                                           input int         n_in);
        if (ofs == OFS_STATUS) return REG_STATUS;
        if (ofs == OFS_MASK)   return REG_MASK;
        if (int'(ofs) >= int'(OFS_OUT0) && int'(ofs) < int'(OFS_OUT0) + n_out) return REG_OUT;
        if (int'(ofs) >= int'(OFS_IN0)  && int'(ofs) < int'(OFS_IN0) + n_in)   return REG_IN;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// io_debounce
// One input channel: two-flop synchroniser followed by a debouncer that only
// accepts a new value after it has been seen unchanged for DEB_CYCLES
// consecutive synchronised cycles.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   pin_i      : raw asynchronous channel input
//   in_o       : accepted (debounced) channel value, IN[k]
//   chg_o      : high in the cycle whose clock edge updates in_o
module io_debounce #(
    parameter int DATA_W     = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pin_i,
    output logic [DATA_W-1:0] in_o,
    output logic              chg_o
);

    localparam int               CNT_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

    logic [DATA_W-1:0] sync1_q, sync2_q;
    logic [DATA_W-1:0] cand_q, cand_d;
    logic [DATA_W-1:0] in_q, in_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // The count includes the current cycle: a freshly loaded candidate has
    // been seen once, so a value seen on DEB_CYCLES consecutive edges is
    // accepted on the last of them. The count saturates at DEB_CYCLES.
    always_comb begin
        cand_d = sync2_q;
        if (sync2_q != cand_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        in_d = in_q;
        if (cnt_d == CNT_MAX && sync2_q != in_q) begin
            in_d = sync2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            in_q    <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            in_q    <= in_d;
        end
    end

    assign in_o  = in_q;
    assign chg_o = (in_d != in_q);

endmodule

// File: rtl/parallel_io_bank.sv
// parallel_io_bank
// Memory-mapped parallel I/O bank sitting between the CPU data port and the
// data RAM. Addresses inside the 16-address window at BASE_ADDR are served
// here; everything else passes through to RAM.
//   offset 0..N_OUT-1 : OUT[k]   read/write, drives pin_out
//   offset 8..8+N_IN-1: IN[k]    read-only, debounced pin_in
//   offset 14         : STATUS   bit k set when IN[k] changes, write-1-to-clear
//   offset 15         : MASK     read/write interrupt enables
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   address    : CPU data address
//   we         : CPU store strobe
//   wr_data    : CPU store data
//   mem_rdata  : data RAM read data
//   rd_data    : load data back to the CPU (combinational)
//   mem_wren   : RAM write enable, suppressed for I/O addresses
//   pin_in     : raw external inputs, channel k at [k*DATA_W +: DATA_W]
//   pin_out    : registered external outputs, same packing
//   irq        : OR of STATUS & MASK
module parallel_io_bank
    import io_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 8,
    parameter int                N_IN       = 2,
    parameter int                N_OUT      = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 'hF0,
    parameter int                DEB_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    we,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    mem_wren,
    input  logic [N_IN*DATA_W-1:0]  pin_in,
    output logic [N_OUT*DATA_W-1:0] pin_out,
    output logic                    irq
);

    logic [3:0]        offset;
    logic              io_hit;
    logic              io_we;
    io_reg_e           reg_sel;
    logic [3:0]        out_idx;
    logic [3:0]        in_idx;

    logic [DATA_W-1:0] out_q [N_OUT];
    logic [DATA_W-1:0] out_d [N_OUT];
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [N_IN-1:0]   status_q, status_d;
    logic [DATA_W-1:0] in_val [N_IN];
    logic [N_IN-1:0]   in_chg;
    logic [DATA_W-1:0] io_rdata;

    assign offset   = address[IO_WIN_BITS-1:0];
    assign io_hit   = (address[ADDR_W-1:IO_WIN_BITS] == BASE_ADDR[ADDR_W-1:IO_WIN_BITS]);
    assign io_we    = we & io_hit;
    assign mem_wren = we & ~io_hit;
    assign reg_sel  = decode_ofs(offset, N_OUT, N_IN);
    assign out_idx  = offset - OFS_OUT0;
    assign in_idx   = offset - OFS_IN0;

    for (genvar k = 0; k < N_IN; k++) begin : g_in
        io_debounce #(
            .DATA_W     (DATA_W),
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .pin_i (pin_in[k*DATA_W +: DATA_W]),
            .in_o  (in_val[k]),
            .chg_o (in_chg[k])
        );
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign pin_out[k*DATA_W +: DATA_W] = out_q[k];
    end

    // Next-state for the CPU-visible registers. A change event on a STATUS
    // bit is ORed in after the clear so a coincident set wins.
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            out_d[k] = out_q[k];
            if (io_we && reg_sel == REG_OUT && out_idx == 4'(k)) begin
                out_d[k] = wr_data;
            end
        end
        mask_d = mask_q;
        if (io_we && reg_sel == REG_MASK) begin
            mask_d = wr_data;
        end
        status_d = status_q;
        if (io_we && reg_sel == REG_STATUS) begin
            status_d = status_q & ~wr_data[N_IN-1:0];
        end
        status_d = status_d | in_chg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_OUT; k++) begin
                out_q[k] <= '0;
            end
            mask_q   <= '0;
            status_q <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                out_q[k] <= out_d[k];
            end
            mask_q   <= mask_d;
            status_q <= status_d;
        end
    end

    // Zero-latency read mux; unimplemented offsets and STATUS bits >= N_IN read 0.
    always_comb begin
        io_rdata = '0;
        case (reg_sel)
            REG_OUT: begin
                for (int k = 0; k < N_OUT; k++) begin
                    if (out_idx == 4'(k)) io_rdata = out_q[k];
                end
            end
            REG_IN: begin
                for (int k = 0; k < N_IN; k++) begin
                    if (in_idx == 4'(k)) io_rdata = in_val[k];
                end
            end
            REG_STATUS: io_rdata[N_IN-1:0] = status_q;
            REG_MASK:   io_rdata = mask_q;
            default:    io_rdata = '0;
        endcase
    end

    assign rd_data = io_hit ? io_rdata : mem_rdata;
    assign irq     = |(status_q & mask_q[N_IN-1:0]);

endmodule

// File: doc/parallel_io_bank.md
PARALLEL_IO_BANK -- requirements
Module: parallel_io_bank

Interface
REQ-001 Parameter DATA_W, default 8, width of data bus and of every I/O channel.
REQ-002 Parameter ADDR_W, default 8, width of the data-memory address bus.
REQ-003 Parameter N_IN, default 2, number of input channels; legal range 1..6.
REQ-004 Parameter N_OUT, default 2, number of output channels; legal range 1..8.
REQ-005 Parameter BASE_ADDR, default 8'hF0, base of the 16-address I/O window; low 4 bits zero.
REQ-006 Parameter DEB_CYCLES, default 4, consecutive stable cycles required to accept an input change; minimum 1.
REQ-007 clk  in  1  single clock for the whole block.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 address  in  ADDR_W  CPU data address (ALU result).
REQ-010 we  in  1  CPU store strobe (MemWrite).
REQ-011 wr_data  in  DATA_W  CPU store data (rd2).
REQ-012 mem_rdata  in  DATA_W  read data from data RAM.
REQ-013 rd_data  out  DATA_W  load data returned to the register-file write mux.
REQ-014 mem_wren  out  1  gated write enable to data RAM.
REQ-015 pin_in  in  N_IN*DATA_W  raw external inputs, channel k at bits [k*DATA_W +: DATA_W].
REQ-016 pin_out  out  N_OUT*DATA_W  registered external outputs, same packing.
REQ-017 irq  out  1  OR of (STATUS & MASK).

Function
REQ-018 io_hit SHALL be true when address[ADDR_W-1:4] equals BASE_ADDR[ADDR_W-1:4].
REQ-019 Map (offset = address[3:0]): 0..N_OUT-1 OUT[k] RW; 8..8+N_IN-1 IN[k] RO; 14 STATUS RO/W1C; 15 MASK RW; all other offsets read 0, writes ignored.
REQ-020 mem_wren SHALL equal we AND NOT io_hit, combinationally.
REQ-021 rd_data SHALL be combinational: selected register when io_hit, else mem_rdata; zero-latency read.
REQ-022 OUT[k] and MASK SHALL update at the clk edge where we, io_hit and matching offset are all true; write data visible on pin_out the following cycle.
REQ-023 Each input channel SHALL pass a two-flop synchroniser, then a debouncer: counter clears when synced value differs from candidate, candidate reloads; when candidate holds DEB_CYCLES cycles and differs from IN[k], IN[k] takes candidate and counter stops.
REQ-024 STATUS bit k SHALL set in the cycle IN[k] changes; bits >= N_IN read 0.
REQ-025 A write to STATUS SHALL clear each bit where wr_data is 1; a set event on the same cycle on the same bit wins (bit stays 1).
REQ-026 irq SHALL be registered-free: combinational OR of STATUS[N_IN-1:0] & MASK[N_IN-1:0].
REQ-027 Debounce counters SHALL saturate, never wrap; width clog2(DEB_CYCLES+1).
REQ-028 Input pulses shorter than DEB_CYCLES synced cycles SHALL NOT change IN[k] or STATUS.

Reset
REQ-029 On reset high at clk edge: OUT[*]=0, pin_out=0, MASK=0, STATUS=0, IN[*]=0, candidates=0, counters=0, synchronisers=0.
REQ-030 Reset asserted mid-debounce SHALL abandon the pending change; STATUS SHALL not set from pre-reset activity.
REQ-031 Inputs already high at reset release SHALL produce a normal debounced change and STATUS set.

Structure
REQ-032 Register offsets (OFS_OUT0=0, OFS_IN0=8, OFS_STATUS=14, OFS_MASK=15) SHALL live in shared package/include io_pkg.
REQ-033 One sub-module io_debounce (synchroniser+counter, one per input channel, generate-instanced).
REQ-034 RTL SHALL replace the existing fixed-address parallel in/out pair in the CPU top.

Verification (DATA_W=8, BASE_ADDR=F0, DEB_CYCLES=4, N_IN=2, N_OUT=2)
REQ-035 Store 8'h5A to F1 -> mem_wren=0, pin_out[15:8]=5A next cycle; store to 20 -> mem_wren=1, pin_out unchanged.
REQ-036 pin_in[7:0] 00->3C held -> IN0 reads 3C exactly 2+4 cycles later, STATUS=01; load from 30 returns mem_rdata.
REQ-037 pin_in[15:8] 3-cycle glitch to FF -> IN1 stays 00, STATUS stays 00.
REQ-038 MASK=02, IN1 change -> irq=1; write 02 to FE -> STATUS=00, irq=0; W1C coincident with new set -> bit remains 1.
REQ-039 Reset asserted 2 cycles into debounce of 77 on channel 0 -> all regs 0 after edge, pin_out=0, irq=0; pin_in still 77 -> IN0=77 after full debounce.
REQ-040 Read unmapped offset F5 -> rd_data=00; write to F5 -> no state change, mem_wren=0.
